// File: rtl/mainfsm_if.sv
// Control interface between the multicycle main FSM and the RV32I datapath.
// The master side is the FSM: it reads opcode/status and drives every datapath control.
interface mainfsm_if;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic       IllegalOp;

    modport master (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, IllegalOp
    );

    modport slave (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, IllegalOp
    );
endinterface

// File: rtl/mainfsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port that may insert wait states via MemReady.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_FETCH    | read instruction at PC, PC+4 computed; IR/PC load when MemReady
// S_DECODE   | register read, branch/jump target into ALUOut, dispatch on op
// S_MEMADR   | rs1 + imm effective address for lw/sw
// S_MEMREAD  | load access at ALUOut, wait for MemReady
// S_MEMWB    | write loaded data to rd
// S_MEMWRITE | store access at ALUOut, MemWrite held until MemReady
// S_EXECUTER | R-type ALU operation
// S_EXECUTEI | I-type ALU operation
// S_ALUWB    | write ALUOut to rd
// S_BEQ      | compare rs1/rs2, PC takes target when Zero
// S_JAL      | PC takes target, ALU forms return address OldPC+4
module mainfsm (
    input  logic      clk,
    input  logic      reset,
    mainfsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q, state_d;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_update  = bus.MemReady;
                state_d    = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (bus.op == OP_LW)
                    state_d = S_MEMREAD;
                else if (bus.op == OP_SW)
                    state_d = S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = bus.MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = bus.MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // Write enables are gated by reset so an abandoned instruction cannot commit anything.
    assign bus.PCWrite   = ~reset & (pc_update | (branch & bus.Zero));
    assign bus.IRWrite   = ~reset & ir_write;
    assign bus.MemWrite  = ~reset & mem_write;
    assign bus.RegWrite  = ~reset & reg_write;
    assign bus.IllegalOp = ~reset & illegal;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: each driven cycle queues its expected control word,
// which is popped and compared on the following falling edge.
module tb_mainfsm;

    typedef struct {
        string       tag;
        logic [13:0] exp;
        logic [13:0] mask;
    } exp_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, IllegalOp}
    localparam logic [13:0] W_FETCH = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_FWAIT = {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_DEC   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_ILL   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1};
    localparam logic [13:0] W_MADR  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_MRD   = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_MWB   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [13:0] W_MWBR  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_MWR   = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] W_EXR   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [13:0] W_EXI   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
    localparam logic [13:0] W_AWB   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [13:0] W_BEQT  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
    localparam logic [13:0] W_BEQN  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
    localparam logic [13:0] W_JAL   = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [13:0] M_ALL   = 14'h3FFF;
    localparam logic [13:0] M_EN    = 14'h2C03;

    logic        clk;
    logic        reset;
    logic [13:0] obs;
    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;

    mainfsm_if bus ();

    mainfsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.IllegalOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, {18'd0, obs & e.mask}, {18'd0, e.exp & e.mask});
        end
    end

    task automatic step(input logic rst, input logic [6:0] o, input logic z, input logic mr,
                        input logic [13:0] e, input logic [13:0] m, input string tag);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.op       = o;
        bus.Zero     = z;
        bus.MemReady = mr;
        sb_q.push_back('{tag: tag, exp: e, mask: m});
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // op is random in FETCH: the IR has not been loaded yet, so op must not matter there
    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            step(1'b0, 7'($urandom), rbit(), 1'b0, W_FWAIT, M_ALL, "fetch_wait");
        step(1'b0, 7'($urandom), rbit(), 1'b1, W_FETCH, M_ALL, "fetch");
    endtask

    task automatic run_lw(input int fw, input int rw);
        do_fetch(fw);
        step(1'b0, OP_LW, rbit(), rbit(), W_DEC, M_ALL, "lw_decode");
        step(1'b0, OP_LW, rbit(), rbit(), W_MADR, M_ALL, "lw_memadr");
        for (int i = 0; i < rw; i++)
            step(1'b0, OP_LW, rbit(), 1'b0, W_MRD, M_ALL, "lw_memread_wait");
        step(1'b0, OP_LW, rbit(), 1'b1, W_MRD, M_ALL, "lw_memread");
        step(1'b0, OP_LW, rbit(), rbit(), W_MWB, M_ALL, "lw_memwb");
    endtask

    task automatic run_sw(input int fw, input int ww);
        do_fetch(fw);
        step(1'b0, OP_SW, rbit(), rbit(), W_DEC, M_ALL, "sw_decode");
        step(1'b0, OP_SW, rbit(), rbit(), W_MADR, M_ALL, "sw_memadr");
        for (int i = 0; i < ww; i++)
            step(1'b0, OP_SW, rbit(), 1'b0, W_MWR, M_ALL, "sw_memwrite_wait");
        step(1'b0, OP_SW, rbit(), 1'b1, W_MWR, M_ALL, "sw_memwrite");
    endtask

    task automatic run_alu(input logic [6:0] o, input logic [13:0] ex, input string tag);
        do_fetch(0);
        step(1'b0, o, rbit(), rbit(), W_DEC, M_ALL, "alu_decode");
        step(1'b0, o, rbit(), rbit(), ex, M_ALL, tag);
        step(1'b0, o, rbit(), rbit(), W_AWB, M_ALL, "alu_writeback");
    endtask

    task automatic run_jal();
        do_fetch(0);
        step(1'b0, OP_JAL, rbit(), rbit(), W_DEC, M_ALL, "jal_decode");
        step(1'b0, OP_JAL, rbit(), rbit(), W_JAL, M_ALL, "jal_pcwrite");
        step(1'b0, OP_JAL, rbit(), rbit(), W_AWB, M_ALL, "jal_writeback");
    endtask

    task automatic run_beq(input logic z);
        do_fetch(0);
        step(1'b0, OP_BEQ, rbit(), rbit(), W_DEC, M_ALL, "beq_decode");
        step(1'b0, OP_BEQ, z, rbit(), z ? W_BEQT : W_BEQN, M_ALL, z ? "beq_taken" : "beq_not_taken");
    endtask

    task automatic run_illegal(input logic [6:0] o);
        do_fetch(0);
        step(1'b0, o, rbit(), rbit(), W_ILL, M_ALL, "illegal_decode");
    endtask

    // reset lands in MEMREAD (at_wb=0) or MEMWB (at_wb=1); the next do_fetch is the release cycle
    task automatic run_lw_reset(input logic at_wb);
        do_fetch(0);
        step(1'b0, OP_LW, rbit(), 1'b1, W_DEC, M_ALL, "lwr_decode");
        step(1'b0, OP_LW, rbit(), 1'b1, W_MADR, M_ALL, "lwr_memadr");
        if (at_wb) begin
            step(1'b0, OP_LW, rbit(), 1'b1, W_MRD, M_ALL, "lwr_memread");
            step(1'b1, OP_LW, rbit(), 1'b1, W_MWBR, M_ALL, "lwr_reset_in_memwb");
        end else begin
            step(1'b1, OP_LW, rbit(), 1'b1, W_MRD, M_ALL, "lwr_reset_in_memread");
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.op       = 7'd0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;

        for (int i = 0; i < 3; i++)
            step(1'b1, 7'($urandom), rbit(), 1'b1, 14'd0, M_EN, "reset_enables");

        run_lw(0, 0);
        run_sw(0, 2);
        run_sw(2, 0);
        run_lw(1, 2);
        run_alu(OP_R, W_EXR, "r_execute");
        run_alu(OP_I, W_EXI, "i_execute");
        run_jal();
        run_beq(1'b1);
        run_beq(1'b0);
        run_illegal(7'b0000000);
        run_illegal(7'b0110111);
        run_illegal(7'b1111111);
        run_lw_reset(1'b0);
        run_lw_reset(1'b1);
        run_alu(OP_R, W_EXR, "r_after_reset");
        do_fetch(0);

        repeat (2) @(posedge clk);
        check_eq("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
